// File: rtl/quiz_pkg.sv
// Shared quiz-buzzer definitions: result codes, display glyph codes,
// top-level view IDs and the code-to-glyph helper used by the review screen.
package quiz_pkg;

  // Per-player result code stored for every played question
  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_A    = 2'b01,
    RES_B    = 2'b10,
    RES_ZERO = 2'b11
  } res_t;

  // Top-level views selectable by the host
  typedef enum logic [2:0] {
    VIEW_IDLE   = 3'd0,
    VIEW_LOBBY  = 3'd1,
    VIEW_GAME   = 3'd2,
    VIEW_SCORE  = 3'd3,
    VIEW_REVIEW = 3'd4
  } view_t;

  // Review display mode
  typedef enum logic {
    MODE_SUMMARY = 1'b0,
    MODE_FIRST   = 1'b1
  } mode_t;

  // Digit codes understood by bcd_seg: 0..9 are decimal digits
  localparam logic [7:0] GLYPH_A    = 8'd10;
  localparam logic [7:0] GLYPH_B    = 8'd11;
  localparam logic [7:0] GLYPH_Q    = 8'd20;
  localparam logic [7:0] GLYPH_DASH = 8'd21;
  localparam logic [7:0] NOSHOW     = 8'hFF;

  // Map a result code onto the glyph shown in a player slot
  function automatic logic [7:0] glyph_of(input logic [1:0] code);
    logic [7:0] g;
    case (res_t'(code))
      RES_A:    g = GLYPH_A;
      RES_B:    g = GLYPH_B;
      RES_ZERO: g = 8'd0;
      default:  g = NOSHOW;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/review_question_view_if.sv
// Host-side bundle of the review screen: view selector, buttons, game data
// in; seven-segment, LED and buzzer drive out.
interface review_question_view_if #(
  parameter int N_PLAYERS   = 4,
  parameter int N_QUESTIONS = 9
);
  logic [2:0]                         view;
  logic [4:0]                         bt_edge;
  logic [3:0]                         play_count;
  logic [N_PLAYERS*2*N_QUESTIONS-1:0] player_list;
  logic [7:0]                         seg_out;
  logic [7:0]                         seg_en;
  logic [23:0]                        led;
  logic                               buzzer;

  modport master (
    output view, bt_edge, play_count, player_list,
    input  seg_out, seg_en, led, buzzer
  );

  modport slave (
    input  view, bt_edge, play_count, player_list,
    output seg_out, seg_en, led, buzzer
  );
endinterface

// File: rtl/bcd_seg.sv
// Digit-code to seven-segment decoder, active-low {dp,g,f,e,d,c,b,a}.
// Unknown codes (including NOSHOW) blank the digit.
module bcd_seg
  import quiz_pkg::*;
(
  input  logic [7:0] i_code,
  output logic [7:0] o_seg
);

  // Pure lookup from digit code to segment pattern
  always_comb begin
    case (i_code)
      8'd0:       o_seg = 8'hC0;
      8'd1:       o_seg = 8'hF9;
      8'd2:       o_seg = 8'hA4;
      8'd3:       o_seg = 8'hB0;
      8'd4:       o_seg = 8'h99;
      8'd5:       o_seg = 8'h92;
      8'd6:       o_seg = 8'h82;
      8'd7:       o_seg = 8'hF8;
      8'd8:       o_seg = 8'h80;
      8'd9:       o_seg = 8'h90;
      GLYPH_A:    o_seg = 8'h88;
      GLYPH_B:    o_seg = 8'h83;
      GLYPH_Q:    o_seg = 8'h98;
      GLYPH_DASH: o_seg = 8'hBF;
      default:    o_seg = 8'hFF;
    endcase
  end

endmodule

// File: rtl/review_question_view_cursor.sv
// review_cursor: question cursor with wrap, clamp and the change strobe that
// drives the navigation beep. Build with REVIEW_AUTOPLAY_EN to add the
// auto-advance counter; otherwise the autoplay toggle is ignored.
module review_cursor #(
  parameter int AUTO_TICKS = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_active,
  input  logic [3:0] i_max_q,
  input  logic       i_right,
  input  logic       i_left,
  input  logic       i_mode,
  input  logic       i_auto_toggle,
  output logic [3:0] o_cursor,
  output logic       o_changed,
  output logic       o_autoplay
);

  logic [3:0] r_cursor;
  logic       r_changed;
  logic       w_right;
  logic       w_left;
  logic [3:0] w_fwd;
  logic [3:0] w_back;
  logic       w_auto_fire;

  // Pressing both directions at once cancels out
  assign w_right = i_right & ~i_left;
  assign w_left  = i_left & ~i_right;
  assign w_fwd   = (r_cursor == i_max_q) ? 4'd1 : r_cursor + 4'd1;
  assign w_back  = (r_cursor == 4'd1) ? i_max_q : r_cursor - 4'd1;

`ifdef REVIEW_AUTOPLAY_EN
  localparam int AW = $clog2(AUTO_TICKS + 1);

  logic          r_auto;
  logic [AW-1:0] r_auto_cnt;
  logic          w_restart;

  assign w_restart   = i_right | i_left | i_mode | i_auto_toggle;
  assign w_auto_fire = r_auto & (r_auto_cnt == AW'(AUTO_TICKS - 1));

  // Autoplay enable and period counter; any navigation restarts the period
  always_ff @(posedge clk) begin
    if (rst || !i_active || i_max_q <= 4'd1) begin
      r_auto     <= 1'b0;
      r_auto_cnt <= '0;
    end else begin
      if (i_auto_toggle) r_auto <= ~r_auto;
      if (!r_auto || w_restart || w_auto_fire) r_auto_cnt <= '0;
      else                                     r_auto_cnt <= r_auto_cnt + 1'b1;
    end
  end

  assign o_autoplay = r_auto;
`else
  localparam int AUTO_TICKS_UNUSED = AUTO_TICKS;
  logic w_unused_auto;
  assign w_unused_auto = i_mode ^ i_auto_toggle;
  assign w_auto_fire   = 1'b0;
  assign o_autoplay    = 1'b0;
`endif

  // Cursor update: clamp first, then entry load, then navigation
  always_ff @(posedge clk) begin
    if (rst || !i_active) begin
      r_cursor  <= 4'd0;
      r_changed <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      if (r_cursor > i_max_q) begin
        r_cursor <= i_max_q;
      end else if (r_cursor == 4'd0) begin
        if (i_max_q != 4'd0) r_cursor <= 4'd1;
      end else if (w_right || (!w_left && w_auto_fire)) begin
        r_cursor  <= w_fwd;
        r_changed <= (w_fwd != r_cursor);
      end else if (w_left) begin
        r_cursor  <= w_back;
        r_changed <= (w_back != r_cursor);
      end
    end
  end

  assign o_cursor  = r_cursor;
  assign o_changed = r_changed;

endmodule

// File: rtl/seg_tube.sv
// Eight-digit multiplex scanner: every SCAN_TICKS cycles it moves to the next
// digit; seg_en bit i (active-low) enables digit i, seg_out carries its pattern.
module seg_tube #(
  parameter int SCAN_TICKS = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] i_segs,
  output logic [7:0]  o_seg_out,
  output logic [7:0]  o_seg_en
);

  localparam int DW = $clog2(SCAN_TICKS + 1);

  logic [DW-1:0] r_div;
  logic [2:0]    r_idx;
  logic [7:0]    r_seg_out;
  logic [7:0]    r_seg_en;

  // Scan divider, digit index and registered digit drive
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_idx     <= '0;
      r_seg_out <= 8'hFF;
      r_seg_en  <= 8'hFF;
    end else begin
      r_seg_en  <= ~(8'd1 << r_idx);
      r_seg_out <= i_segs[{r_idx, 3'b000} +: 8];
      if (r_div == DW'(SCAN_TICKS - 1)) begin
        r_div <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_seg_out = r_seg_out;
  assign o_seg_en  = r_seg_en;

endmodule

// File: rtl/review_question_view.sv
// Post-game review screen: steps through played questions and shows every
// player's result (SUMMARY) or only the first answerer (FIRST) on the
// eight-digit display, LEDs and buzzer. Optional auto-advance is built when
// REVIEW_AUTOPLAY_EN is defined.
module review_question_view
  import quiz_pkg::*;
#(
  parameter int         N_PLAYERS   = 4,
  parameter int         N_QUESTIONS = 9,
  parameter logic [2:0] VIEW_ID     = 3'(VIEW_REVIEW),
  parameter int         BEEP_TICKS  = 5_000_000,
  parameter int         AUTO_TICKS  = 100_000_000,
  parameter int         SCAN_TICKS  = 100_000
) (
  input logic                   clk,
  input logic                   rst,
  review_question_view_if.slave bus
);

  localparam int BW = $clog2(BEEP_TICKS + 1);

  logic                   w_active;
  logic [3:0]             w_max_q;
  logic [3:0]             w_cursor;
  logic                   w_changed;
  logic                   w_autoplay;
  logic [3:0]             w_qidx;
  logic                   w_qvalid;
  logic [2*N_PLAYERS-1:0] w_codes;
  logic [2:0]             w_first;
  logic [7:0]             w_digit_next [8];
  logic [23:0]            w_led_next;
  logic [63:0]            w_seg;
  logic [7:0]             w_seg_out;
  logic [7:0]             w_seg_en;
  logic                   w_unused_btn;
  mode_t                  r_mode;
  logic [7:0]             r_digit [8];
  logic [23:0]            r_led;
  logic [BW-1:0]          r_beep;

  assign w_active     = ~rst & (bus.view == VIEW_ID);
  assign w_max_q      = (bus.play_count < 4'(N_QUESTIONS)) ? bus.play_count : 4'(N_QUESTIONS);
  assign w_unused_btn = bus.bt_edge[4];

  review_cursor #(.AUTO_TICKS(AUTO_TICKS)) u_cursor (
    .clk           (clk),
    .rst           (rst),
    .i_active      (w_active),
    .i_max_q       (w_max_q),
    .i_right       (bus.bt_edge[0]),
    .i_left        (bus.bt_edge[1]),
    .i_mode        (bus.bt_edge[2]),
    .i_auto_toggle (bus.bt_edge[3]),
    .o_cursor      (w_cursor),
    .o_changed     (w_changed),
    .o_autoplay    (w_autoplay)
  );

  // Result code of every player for the selected question (00 when none)
  assign w_qidx   = w_cursor - 4'd1;
  assign w_qvalid = (w_cursor != 4'd0) && (w_cursor <= 4'(N_QUESTIONS));

  genvar gi;
  generate
    for (gi = 0; gi < N_PLAYERS; gi++) begin : g_code
      logic [2*N_QUESTIONS-1:0] w_row;
      assign w_row = bus.player_list[gi*2*N_QUESTIONS +: 2*N_QUESTIONS];
      assign w_codes[2*gi +: 2] = w_qvalid ? w_row[{w_qidx, 1'b0} +: 2] : 2'b00;
    end
  endgenerate

  // Digit and LED contents derived from cursor, mode and codes
  always_comb begin
    w_first = 3'(N_PLAYERS);
    for (int p = N_PLAYERS - 1; p >= 0; p--)
      if (w_codes[2*p +: 2] != 2'b00) w_first = 3'(p);

    for (int i = 0; i < 8; i++) w_digit_next[i] = NOSHOW;
    w_digit_next[0] = GLYPH_Q;
    if (w_cursor == 4'd0) begin
      w_digit_next[1] = GLYPH_DASH;
      w_digit_next[2] = GLYPH_DASH;
    end else if (w_cursor >= 4'd10) begin
      w_digit_next[1] = 8'd1;
      w_digit_next[2] = {4'd0, w_cursor - 4'd10};
    end else begin
      w_digit_next[2] = {4'd0, w_cursor};
    end

    w_led_next = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      w_led_next[p] = |w_codes[2*p +: 2];
      if (r_mode == MODE_SUMMARY || w_first == 3'(p))
        w_digit_next[7-p] = glyph_of(w_codes[2*p +: 2]);
    end
    w_led_next[19:16] = w_cursor;
    w_led_next[22]    = (r_mode == MODE_FIRST);
    w_led_next[23]    = w_autoplay;
  end

  // Display mode toggles on the mode button, reverts to SUMMARY when inactive
  always_ff @(posedge clk) begin
    if (!w_active)         r_mode <= MODE_SUMMARY;
    else if (bus.bt_edge[2]) r_mode <= (r_mode == MODE_SUMMARY) ? MODE_FIRST : MODE_SUMMARY;
  end

  // Registered digit codes and LEDs, blanked while the view is not shown
  always_ff @(posedge clk) begin
    if (!w_active) begin
      for (int i = 0; i < 8; i++) r_digit[i] <= NOSHOW;
      r_led <= '0;
    end else begin
      for (int i = 0; i < 8; i++) r_digit[i] <= w_digit_next[i];
      r_led <= w_led_next;
    end
  end

  // Beep counter: reloaded on every navigation change, counts down to zero
  always_ff @(posedge clk) begin
    if (!w_active)             r_beep <= '0;
    else if (w_changed)        r_beep <= BW'(BEEP_TICKS);
    else if (r_beep != '0)     r_beep <= r_beep - 1'b1;
  end

  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      bcd_seg u_dec (.i_code(r_digit[gi]), .o_seg(w_seg[8*gi +: 8]));
    end
  endgenerate

  seg_tube #(.SCAN_TICKS(SCAN_TICKS)) u_tube (
    .clk       (clk),
    .rst       (rst),
    .i_segs    (w_seg),
    .o_seg_out (w_seg_out),
    .o_seg_en  (w_seg_en)
  );

  assign bus.seg_out = w_seg_out;
  assign bus.seg_en  = w_seg_en;
  assign bus.led     = r_led;
  assign bus.buzzer  = (r_beep != '0);

endmodule

// File: doc/review_question_view.md
# review_question_view

Parametrised post-game review screen for the quiz-buzzer system. When the top-level view selector equals `VIEW_ID`, this block lets the host step through every played question. For each question it shows, on the 8-digit seven-segment display, LEDs and buzzer, the result code of every player (summary mode) or of the first answering player only (first mode). With `AUTOPLAY_EN` compiled in, it can also auto-advance through the questions.

## Interface
Parameters:
- `N_PLAYERS`, 4 — number of player slots; range 1..4.
- `N_QUESTIONS`, 9 — questions stored per player; range 1..15.
- `VIEW_ID`, 4 — value of `view` that activates the block.
- `BEEP_TICKS`, 5_000_000 — buzzer pulse length in clk cycles.
- `AUTO_TICKS`, 100_000_000 — auto-advance period in clk cycles; used only with `AUTOPLAY_EN`.

Ports:
- `clk` in 1 — system clock.
- `rst` in 1 — reset, synchronous, active-high. Clock is `clk`.
- `view` in 3 — current top-level view.
- `bt_edge` in 5 — single-cycle button pulses: [0] right, [1] left, [2] mode toggle, [3] autoplay toggle.
- `play_count` in 4 — number of questions played.
- `player_list` in `N_PLAYERS*2*N_QUESTIONS` — player p (0-based) question q (1-based) code at bits [p*2*N_QUESTIONS + 2(q-1) +: 2].
- `seg_out` out 8 — segment drive, active-low.
- `seg_en` out 8 — digit enable, active-low.
- `led` out 24 — status LEDs.
- `buzzer` out 1 — navigation beep.

## Operation
- **Derived limit:** `max_q = min(play_count, N_QUESTIONS)`, computed combinationally.
- **Cursor range:** the cursor is 4 bits wide, 0..`max_q`. A value of 0 means no question is selected.
- **Inactive:** when `rst` is high or `view != VIEW_ID`, the block forces these values every cycle:
  - cursor = 0, mode = SUMMARY, autoplay = off;
  - all eight digit registers blank (8'hFF), `led` = 0, `buzzer` = 0, beep counter = 0.
- **Entry:** in the first active cycle with cursor = 0, the cursor loads 1 if `max_q` ≥ 1. If `max_q` = 0 it stays 0.
- **Right press:** cursor = `max_q` wraps to 1; otherwise the cursor increments.
- **Left press:** cursor = 1 wraps to `max_q`; otherwise the cursor decrements.
- **Simultaneous left and right:** both are ignored. Presses are ignored while `max_q` = 0.
- **Clamp:** if `max_q` drops below the cursor, the cursor is set to `max_q` on the next cycle. Clamp has priority over presses.
- **Mode toggle:** `bt_edge[2]` toggles between SUMMARY and FIRST.
- **Result glyphs:** code 01 → 'A' (bcd 10), 10 → 'b' (bcd 11), 11 → '0', 00 → blank.
- **Display layout:**
  - digit0 = GLYPH_Q;
  - digit1 = tens of the cursor, blank if the cursor < 10;
  - digit2 = ones of the cursor; if the cursor = 0, digits 1..2 show GLYPH_DASH;
  - digit3 = blank;
  - player p (1-based) uses digit 8-p, so player 1 is digit7.
  - Slots for players above `N_PLAYERS` are blank.
- **SUMMARY mode:** every player slot shows its glyph.
- **FIRST mode:** only the lowest-numbered player with a nonzero code is shown; all other player slots are blank.
- **LEDs:**
  - `led[p-1]` = 1 when player p's code for the cursor question is nonzero;
  - `led[19:16]` = cursor;
  - `led[22]` = 1 in FIRST mode;
  - `led[23]` = autoplay state;
  - all other bits are 0.
- **Buzzer:** every cursor change between two nonzero values (press or auto-advance) loads the beep counter with `BEEP_TICKS`. `buzzer` = 1 while the counter is nonzero. A new change reloads the counter. The entry load from 0 to 1 does not beep.

## Timing
- Cursor, mode and autoplay registers update on the clk edge after the pulse.
- Digit registers and `led` are registered from the cursor, so a button edge appears on them after 2 cycles.
- `buzzer` rises 2 cycles after the edge and stays high for exactly `BEEP_TICKS` cycles.
- `seg_out`/`seg_en` follow the digit registers with the scanner's own multiplex latency.
- A reset or view exit mid-beep or mid-autoplay clears everything in the next cycle.

## Configuration
- **Macro:** `REVIEW_AUTOPLAY_EN`.
- **Defined:**
  - `bt_edge[3]` toggles autoplay.
  - While autoplay is on, a counter advances the cursor exactly as a right press every `AUTO_TICKS` cycles.
  - Any left or right press, or a mode toggle, restarts the counter.
  - Autoplay is forced off when `max_q` ≤ 1.
- **Undefined:** no counter is built, `bt_edge[3]` is ignored and `led[23]` = 0.

## Structure
- **Shared package `quiz_pkg`** holds:
  - result codes (NONE = 00, A = 01, B = 10, ZERO = 11);
  - GLYPH_Q, GLYPH_DASH and NOSHOW = 8'hFF;
  - the view ID enum.
- **Sub-module `review_cursor`:** the natural split. It contains cursor, wrap, clamp, autoplay counter and change strobe, and outputs `cursor[3:0]` and `changed`.
- **Reuse:** the existing `seg_tube` scanner and `bcd_seg` decoders are instantiated unchanged.

## Test plan
- **Entry and slot decode:** `play_count` = 3, question-1 codes P1 = 01, P2 = 10, P3 = 00, P4 = 11; enter view 4.
  - After 2 cycles: digits are Q, blank, 1, blank, '0', blank, 'b', 'A'.
  - `led[3:0]` = 4'b1011, `led[19:16]` = 1.
- **Wrap:** from cursor 1, press left → cursor 3 with one `BEEP_TICKS` pulse. Press right → cursor 1.
- **FIRST mode and simultaneous press:** press mode on question 1 → only digit7 shows 'A', `led[22]` = 1. Press left and right in the same cycle → cursor unchanged, no beep.
- **Clamp and empty game:**
  - Cursor 3, drop `play_count` to 2 → cursor 2 next cycle.
  - `play_count` = 0 → cursor 0, digits 1..2 show dash, presses ignored.
- **Exit:** set `view` = 2 mid-beep → next cycle `buzzer` = 0, `led` = 0, all digits blank; re-entry starts at question 1 in SUMMARY mode.
- **Autoplay (`REVIEW_AUTOPLAY_EN`, `AUTO_TICKS` = 8):**
  - Toggle autoplay → cursor advances every 8 cycles, wrapping 3 → 1.
  - A right press restarts the 8-cycle count.
  - Without the macro, `bt_edge[3]` has no effect.
